alu_switch_top: RTL and testbench

FPGA board-level ALU wrapper. Operand A, operand B and the opcode are loaded one at a time from a shared bank of switches, each captured by its own push-button. A combinational ALU drives the LEDs from the three stored values. Internally it is a register/capture stage followed by a parameterised ALU.

---
 rtl/alu_switch_top.sv | 67 ++++++
 tb/tb_alu_switch_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_switch_top.sv
// ============================================================================
// Module : alu_switch_top
// Switch-loaded A/B/OP capture registers feeding a combinational ALU to LEDs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_switch_top #(
   parameter int NB_BTN = 3,
   parameter int NB_OP  = 6,
   parameter int NB_AB  = 6
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_AB-1:0]  i_sw,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_AB-1:0]  o_led
);

   localparam logic [NB_OP-1:0] c_OP_ADD = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] c_OP_SUB = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] c_OP_AND = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] c_OP_OR  = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] c_OP_XOR = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] c_OP_NOR = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] c_OP_SRA = NB_OP'(6'b000011);
   localparam logic [NB_OP-1:0] c_OP_SRL = NB_OP'(6'b000010);

   logic [NB_AB-1:0] r_a;
   logic [NB_AB-1:0] r_b;
   logic [NB_OP-1:0] r_op;
   logic [NB_AB-1:0] w_led;

   // Buttons are level-sampled and independent; reset overrides all of them.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         r_a  <= '0;
         r_b  <= '0;
         r_op <= '0;
      end else begin
         if (i_btn[0]) r_a  <= i_sw;
         if (i_btn[1]) r_b  <= i_sw;
         if (i_btn[2]) r_op <= i_sw[NB_OP-1:0];
      end
   end

   // Shift amount is the full value of B, so large B naturally saturates.
   always_comb begin
      w_led = '0;
      case (r_op)
         c_OP_ADD: w_led = r_a + r_b;
         c_OP_SUB: w_led = r_a - r_b;
         c_OP_AND: w_led = r_a & r_b;
         c_OP_OR:  w_led = r_a | r_b;
         c_OP_XOR: w_led = r_a ^ r_b;
         c_OP_NOR: w_led = ~(r_a | r_b);
         c_OP_SRA: w_led = $signed(r_a) >>> r_b;
         c_OP_SRL: w_led = r_a >> r_b;
         default:  w_led = '0;
      endcase
   end

   assign o_led = w_led;

endmodule

`default_nettype wire

// File: tb/tb_alu_switch_top.sv
// ============================================================================
// Module : tb_alu_switch_top
// Scoreboard bench for alu_switch_top: directed loads, queued expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_switch_top;

   localparam int NB_BTN = 3;
   localparam int NB_OP  = 6;
   localparam int NB_AB  = 6;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;

   typedef struct {
      logic [NB_AB-1:0] exp;
      string            name;
   } exp_t;

   logic              clock;
   logic              i_reset;
   logic [NB_AB-1:0]  i_sw;
   logic [NB_BTN-1:0] i_btn;
   logic [NB_AB-1:0]  o_led;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   alu_switch_top #(
      .NB_BTN (NB_BTN),
      .NB_OP  (NB_OP),
      .NB_AB  (NB_AB)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .i_btn   (i_btn),
      .o_led   (o_led)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model; shifts are done one bit at a time.
   function automatic logic [5:0] ref_alu(input logic [5:0] op, input logic [5:0] a,
                                          input logic [5:0] b);
      logic [5:0] v;
      int         s;
      case (op)
         OP_ADD: s = (int'(a) + int'(b)) % 64;
         OP_SUB: s = (int'(a) - int'(b) + 64) % 64;
         OP_AND: s = int'(a & b);
         OP_OR:  s = int'(a | b);
         OP_XOR: s = int'(a ^ b);
         OP_NOR: s = int'(~(a | b));
         OP_SRA, OP_SRL: begin
            v = a;
            for (int k = 0; k < int'(b); k++)
               v = {(op == OP_SRA) ? v[5] : 1'b0, v[5:1]};
            s = int'(v);
         end
         default: s = 0;
      endcase
      return s[5:0];
   endfunction

   // Monitor: o_led is combinational, so the DUT presents a result every cycle;
   // a queued expectation is consumed on the next falling edge.
   always @(negedge clock) begin
      if (q_exp.size() > 0) begin
         exp_t e;
         e = q_exp.pop_front();
         n_checks++;
         if (o_led === e.exp)
            n_pass++;
         else
            $display("FAIL %s: o_led=%b expected=%b", e.name, o_led, e.exp);
      end
   end

   task automatic press(input logic [2:0] btn, input logic [5:0] sw);
      @(posedge clock); #1;
      i_btn = btn;
      i_sw  = sw;
      @(posedge clock); #1;
      i_btn = '0;
   endtask

   task automatic expect_led(input logic [5:0] exp, input string name);
      exp_t e;
      e.exp  = exp;
      e.name = name;
      q_exp.push_back(e);
      @(posedge clock); #1;
   endtask

   task automatic load_all(input logic [5:0] op, input logic [5:0] a, input logic [5:0] b);
      press(3'b100, op);
      press(3'b001, a);
      press(3'b010, b);
   endtask

   logic [5:0] ops [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", q_exp.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] a, b;
      i_reset = 1'b1;
      i_sw    = '0;
      i_btn   = '0;
      repeat (2) @(posedge clock);
      #1;
      i_reset = 1'b0;
      expect_led(6'b000000, "reset_state");

      // Reset clears everything and wins over buttons asserted in the same cycle.
      load_all(OP_ADD, 6'd5, 6'd3);
      expect_led(6'd8, "pre_reset_add");
      @(posedge clock); #1;
      i_reset = 1'b1;
      i_btn   = 3'b111;
      i_sw    = 6'b111111;
      @(posedge clock); #1;
      i_reset = 1'b0;
      i_btn   = '0;
      expect_led(6'b000000, "after_reset");
      for (int i = 0; i < 3; i++) expect_led(6'b000000, "idle_after_reset");
      press(3'b100, OP_OR);
      expect_led(6'b000000, "reset_priority_ab_cleared");

      // Arithmetic wrap.
      load_all(OP_ADD, 6'b111110, 6'b000011);
      expect_led(6'b000001, "add_wrap");
      load_all(OP_SUB, 6'b000001, 6'b000011);
      expect_led(6'b111110, "sub_wrap");

      // Logic ops on one operand pair.
      press(3'b001, 6'b101100);
      press(3'b010, 6'b011010);
      press(3'b100, OP_AND); expect_led(6'b001000, "and");
      press(3'b100, OP_OR);  expect_led(6'b111110, "or");
      press(3'b100, OP_XOR); expect_led(6'b110110, "xor");
      press(3'b100, OP_NOR); expect_led(6'b000001, "nor");

      // Shifts, including B >= width and B = 0.
      load_all(OP_SRA, 6'b100100, 6'b000010); expect_led(6'b111001, "sra_2");
      press(3'b100, OP_SRL);                  expect_led(6'b001001, "srl_2");
      load_all(OP_SRA, 6'b100000, 6'b000111); expect_led(6'b111111, "sra_7");
      press(3'b100, OP_SRL);                  expect_led(6'b000000, "srl_7");
      press(3'b010, 6'b000000);               expect_led(6'b100000, "srl_0");
      press(3'b100, OP_SRA);                  expect_led(6'b100000, "sra_0");

      // Button independence: switches alone do nothing; shared load of A and B.
      load_all(OP_OR, 6'b001111, 6'b000000);
      expect_led(6'b001111, "hold_before_sw_change");
      i_sw = 6'b110000;
      for (int i = 0; i < 3; i++) expect_led(6'b001111, "hold_sw_no_button");
      press(3'b100, OP_ADD);
      press(3'b011, 6'b000101);
      expect_led(6'b001010, "shared_load_ab_add");

      // Held button reloads every cycle.
      @(posedge clock); #1;
      i_btn = 3'b001;
      i_sw  = 6'd1;
      @(posedge clock); #1;
      expect_led(6'd6, "held_btn_a1");
      i_sw = 6'd9;
      @(posedge clock); #1;
      i_btn = '0;
      expect_led(6'd14, "held_btn_a9");

      // Random regression, including two undefined opcodes.
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL,
              6'b000000, 6'b111111};
      foreach (ops[k]) begin
         press(3'b100, ops[k]);
         for (int n = 0; n < 50; n++) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            press(3'b001, a);
            press(3'b010, b);
            expect_led(ref_alu(ops[k], a, b), $sformatf("rand_op%b_a%b_b%b", ops[k], a, b));
         end
      end

      repeat (2) @(posedge clock);
      if (q_exp.size() != 0) begin
         n_checks += q_exp.size();
         $display("FAIL scoreboard_drain: pending=%0d expected=0", q_exp.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
